// File: rtl/cnnpr_pkg.sv
// cnnpr_pkg: shared FSM state type and bit-scan helpers for the sparse row streamer
package cnnpr_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
  localparam int MAX_ROW_LEN = 64;
  function automatic int C_LOG_2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int popcount(input logic [MAX_ROW_LEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_ROW_LEN; i++) n += int'(v[i]);
    return n;
  endfunction
  function automatic int lowest_set(input logic [MAX_ROW_LEN-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_ROW_LEN - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/sparse_row_streamer_if.sv
// sparse_row_streamer_if: row write port, pass control and non-zero activation stream
// master drives wr_req/wr_flag/wr_data, start/pass_rows/rep_num and out_ready;
// slave (the streamer) drives wr_full, busy, pass_done and the out_* beat fields.
interface sparse_row_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN = 16,
  parameter int REP_W = 2,
  parameter int ROW_CNT_W = 4
) ();
  localparam int IDX_W = cnnpr_pkg::C_LOG_2(ROW_LEN);
  logic wr_req;
  logic [ROW_LEN-1:0] wr_flag;
  logic [ROW_LEN*DATA_WIDTH-1:0] wr_data;
  logic wr_full;
  logic start;
  logic [ROW_CNT_W-1:0] pass_rows;
  logic [REP_W-1:0] rep_num;
  logic busy;
  logic pass_done;
  logic out_valid;
  logic out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic [ROW_CNT_W-1:0] out_row;
  logic [IDX_W:0] out_row_val_num;
  logic out_last;
  logic out_zero_flag;
  modport master (
    output wr_req, wr_flag, wr_data, start, pass_rows, rep_num, out_ready,
    input wr_full, busy, pass_done, out_valid, out_data, out_index, out_row, out_row_val_num, out_last, out_zero_flag
  );
  modport slave (
    input wr_req, wr_flag, wr_data, start, pass_rows, rep_num, out_ready,
    output wr_full, busy, pass_done, out_valid, out_data, out_index, out_row, out_row_val_num, out_last, out_zero_flag
  );
endinterface

// File: rtl/row_fifo.sv
// row_fifo: DEPTH-entry synchronous FIFO with async reset and registered occupancy
// ports: push/din write side (dropped when full), pop/dout read side (dout shows head), full, empty.
module row_fifo import cnnpr_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = C_LOG_2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/sparse_row_streamer.sv
// sparse_row_streamer: buffers bitmap-compressed rows and streams their non-zero activations with replay
// ports: clk, reset (async, active-high), bus (slave modport: row write port, start/pass_rows/rep_num,
// busy/pass_done, out_* valid/ready stream). Define SPARSE_ZERO_ROW_BEAT_EN to emit a flagged beat per
// replay of an empty row; otherwise empty rows are skipped silently.
module sparse_row_streamer import cnnpr_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN = 16,
  parameter int DEPTH = 4,
  parameter int REP_W = 2,
  parameter int ROW_CNT_W = 4
) (
  input logic clk,
  input logic reset,
  sparse_row_streamer_if.slave bus
);
  localparam int IDX_W = C_LOG_2(ROW_LEN);
  localparam int EW = ROW_LEN * DATA_WIDTH;
`ifdef SPARSE_ZERO_ROW_BEAT_EN
  localparam bit ZERO_BEAT = 1'b1;
`else
  localparam bit ZERO_BEAT = 1'b0;
`endif
  state_t state;
  logic [ROW_LEN-1:0] cur_flag, mask, head_flag;
  logic [EW-1:0] cur_data, head_data;
  logic [IDX_W:0] val_num;
  logic [ROW_CNT_W-1:0] row_cnt, pass_rows_q;
  logic [REP_W-1:0] rep_cnt, rep_max;
  logic [IDX_W-1:0] idx;
  logic fifo_empty, pop, zero_row, hs;
  row_fifo #(.WIDTH(ROW_LEN + EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(bus.wr_req),
    .din({bus.wr_flag, bus.wr_data}),
    .pop(pop),
    .dout({head_flag, head_data}),
    .full(bus.wr_full),
    .empty(fifo_empty)
  );
  assign pop = state == LOAD && !fifo_empty;
  assign zero_row = ZERO_BEAT && cur_flag == '0;
  assign idx = IDX_W'(lowest_set(MAX_ROW_LEN'(mask)));
  assign hs = bus.out_valid && bus.out_ready;
  assign bus.out_valid = state == EMIT;
  // mask & (mask-1) is zero exactly when at most one bit remains
  assign bus.out_last = bus.out_valid && (zero_row || (mask != '0 && (mask & (mask - 1'b1)) == '0));
  assign bus.out_zero_flag = bus.out_valid && zero_row;
  assign bus.out_data = bus.out_valid && !zero_row ? cur_data[idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.out_index = idx;
  assign bus.out_row = row_cnt;
  assign bus.out_row_val_num = val_num;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.pass_done <= 1'b0;
      row_cnt <= '0;
      rep_cnt <= '0;
      pass_rows_q <= '0;
      rep_max <= '0;
      cur_flag <= '0;
      cur_data <= '0;
      mask <= '0;
      val_num <= '0;
    end else begin
      bus.pass_done <= 1'b0;
      case (state)
        // busy set while still IDLE marks the launch cycle before LOAD
        IDLE: if (bus.busy) state <= LOAD;
          else if (bus.start) begin
            bus.busy <= 1'b1;
            pass_rows_q <= bus.pass_rows;
            rep_max <= bus.rep_num == '0 ? '0 : bus.rep_num - 1'b1;
            row_cnt <= '0;
            rep_cnt <= '0;
          end
        LOAD: if (pop) begin
            cur_flag <= head_flag;
            cur_data <= head_data;
            mask <= head_flag;
            val_num <= (IDX_W+1)'(popcount(MAX_ROW_LEN'(head_flag)));
            if (!ZERO_BEAT && head_flag == '0) begin
              if (row_cnt == pass_rows_q) begin
                state <= DONE;
                bus.pass_done <= 1'b1;
              end else row_cnt <= row_cnt + 1'b1;
            end else state <= EMIT;
          end
        EMIT: if (hs) begin
            mask <= mask & (mask - 1'b1);
            if (bus.out_last) begin
              if (rep_cnt < rep_max) begin
                mask <= cur_flag;
                rep_cnt <= rep_cnt + 1'b1;
              end else if (row_cnt == pass_rows_q) begin
                state <= DONE;
                bus.pass_done <= 1'b1;
              end else begin
                row_cnt <= row_cnt + 1'b1;
                rep_cnt <= '0;
                state <= LOAD;
              end
            end
          end
        default: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/sparse_row_streamer.md
# sparse_row_streamer

Parametrised successor to the activation side of the CNNPR memory controller. It buffers bitmap-compressed activation rows in a DEPTH-entry row FIFO. On `start` it streams only the non-zero activations of each row, one per cycle, over a valid/ready handshake, along with element index, row index and per-row non-zero count. Each row can be replayed a programmable number of times for weight reuse (one pass per non-zero weight in a kernel row). It sits between the write-side loader and the PE array.

## Interface
- `DATA_WIDTH`, 8: activation width.
- `ROW_LEN`, 16: elements per row; bitmap width.
- `DEPTH`, 4: row FIFO entries; power of two, ≥2.
- `REP_W`, 2: width of the replay count.
- `ROW_CNT_W`, 4: width of the row index and pass length.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_req`  in  1  push one row.
- `wr_flag`  in  ROW_LEN  bitmap; bit i=1 means element i is non-zero.
- `wr_data`  in  ROW_LEN*DATA_WIDTH  element i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `wr_full`  out  1  FIFO full.
- `start`  in  1  one-cycle pulse that begins a pass.
- `pass_rows`  in  ROW_CNT_W  rows in the pass, minus 1; latched on start.
- `rep_num`  in  REP_W  emissions per row; latched on start; 0 is treated as 1.
- `busy`  out  1  a pass is active.
- `out_valid` / `out_ready`  out / in  1  stream handshake.
- `out_data`  out  DATA_WIDTH  non-zero activation.
- `out_index`  out  clog2(ROW_LEN)  element position within the row.
- `out_row`  out  ROW_CNT_W  row number within the pass.
- `out_row_val_num`  out  clog2(ROW_LEN)+1  popcount of the current row.
- `out_last`  out  1  final beat of the current emission.
- `out_zero_flag`  out  1  beat marks an empty row.
- `pass_done`  out  1  one-cycle pulse at the end of the pass.

## Operation
- Row FIFO:
  - A push takes effect when `wr_req && !wr_full`.
  - `wr_req` while `wr_full` is dropped. This holds even if a pop occurs in the same cycle, because full is evaluated before the pop.
  - Pointers wrap modulo DEPTH; the count is DEPTH+1 states.
- FSM states: IDLE, LOAD, EMIT, DONE.
- **IDLE:** `start` latches `pass_rows` and `rep_num`, clears `row_cnt` and `rep_cnt`, and sets `busy`. The FSM moves to LOAD. `start` is ignored while `busy`.
- **LOAD:**
  - If the FIFO is empty, stay in LOAD.
  - Otherwise pop the head into `cur_flag`/`cur_data`, copy `cur_flag` into `mask`, and register the popcount. Go to EMIT.
- **EMIT:**
  - `out_valid=1`. `out_index` is the lowest set bit of `mask`, and `out_data` is the element at that index.
  - `out_last=1` when `mask` has exactly one bit set.
  - On a handshake, clear that bit in `mask`.
  - After a handshake on a last beat:
    - If `rep_cnt < max(rep_num,1)-1`: reload `mask` from `cur_flag`, increment `rep_cnt`, stay in EMIT.
    - Else if `row_cnt == pass_rows`: go to DONE.
    - Else: increment `row_cnt`, clear `rep_cnt`, go to LOAD.
- **DONE:** pulse `pass_done` for one cycle, clear `busy`, return to IDLE.
- Empty row (`cur_flag==0`): behaviour is set by the configuration macro.
- All outputs are combinational from registered state. They hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: FIFO empty, `wr_full=0`, state IDLE, `busy=0`, `out_valid=0`, `out_last=0`, `out_zero_flag=0`, `pass_done=0`, and every data, index and count output 0.
- Latency from `start` to first beat:
  - `start` sampled at edge N → LOAD at N+1.
  - With a non-empty FIFO, `out_valid` rises after edge N+2.
- Throughput: one beat per cycle within an emission, and replays run back to back. There is one bubble cycle (LOAD) between rows.
- A row pushed in the same cycle LOAD sees an empty FIFO is popped on the following cycle.
- Reset asserted mid-pass aborts immediately: FIFO contents are discarded and no `pass_done` is issued.

## Configuration
- `SPARSE_ZERO_ROW_BEAT_EN`
  - Defined: an empty row produces one beat per replay with `out_zero_flag=1`, `out_last=1`, `out_data=0`, `out_index=0`.
  - Undefined: empty rows are popped and skipped with no beats, including the `row_cnt`/DONE bookkeeping. `out_zero_flag` is tied to 0.

## Structure
- Shared package `cnnpr_pkg`: FSM state enum, `C_LOG_2` function, and popcount and lowest-set-bit functions.
- Sub-module `row_fifo`: synchronous FIFO, DEPTH × (ROW_LEN + ROW_LEN*DATA_WIDTH), with async reset, `full`/`empty`, and a registered count.

## Test plan
- Push flag `16'h0005` with element0=`8'h11` and element2=`8'h33`; start with `pass_rows=0`, `rep_num=1`, `out_ready=1`.
  - Expect beats (11,idx0), (33,idx2,last); `out_row_val_num=2`; `pass_done` one cycle after the last beat.
- Flag `16'h8001` with `rep_num=3`.
  - Expect indices 0,15,0,15,0,15, with `out_last` on beats 2, 4 and 6 and no bubble between replays.
- Toggle `out_ready` 1,0,0,1 during EMIT.
  - `out_data` and `out_index` stay frozen while stalled, and no beat is lost or duplicated.
- Push flag `16'h0000` with `rep_num=2`.
  - With the macro: two beats with `out_zero_flag=1` and `out_last=1`.
  - Without the macro: zero beats, then `pass_done`.
- Push DEPTH+1 rows with no start.
  - `wr_full` rises after DEPTH pushes, the extra row is dropped, and a pass of DEPTH rows streams exactly the first DEPTH rows.
- Assert `reset` during the second beat of a row.
  - All outputs return to their reset values within the cycle; a subsequent `start` with an empty FIFO holds in LOAD with `out_valid=0`.
